// File: rtl/hb_mac_sched_pkg.sv
// Shared definitions for the halfband MAC scheduler.
// Contents: FSM state type and helpers deriving the filter length (L) and
// the center-tap offset (C) from the number of symmetric tap pairs.
package hb_mac_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_CAPT,
    S_STRB
  } state_t;

  function automatic int unsigned filt_len(input int unsigned ntaps);
    return 4 * ntaps - 1;
  endfunction

  function automatic int unsigned center_off(input int unsigned ntaps);
    return 2 * ntaps - 1;
  endfunction

endpackage

// File: rtl/hb_mac_sched_tap_addr.sv
// hb_tap_addr: combinational tap/coefficient address generator.
// Ports:
//   active     in  - current cycle is a RUN address cycle (outputs are 0 otherwise)
//   base       in  - ring address of the newest sample of the computation
//   k          in  - tap-pair index 0..NTAPS (NTAPS selects the center tap)
//   rd_addr_a  out - leading tap address, base-2k (center: base-C)
//   rd_addr_b  out - trailing tap address, base-(L-1)+2k (center: 0)
//   center_tap out - center-tap cycle
//   coeff_addr out - coefficient index k
module hb_tap_addr
  import hb_mac_sched_pkg::*;
#(
  parameter int unsigned NTAPS  = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              active,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  k,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic              center_tap,
  output logic [ADDR_W-1:0] coeff_addr
);

  localparam int unsigned L = filt_len(NTAPS);
  localparam int unsigned C = center_off(NTAPS);

  logic [ADDR_W-1:0] k2;

  // All arithmetic wraps mod 2**ADDR_W, matching the sample ring.
  assign k2 = ADDR_W'({k, 1'b0});

  always_comb begin
    rd_addr_a  = '0;
    rd_addr_b  = '0;
    center_tap = 1'b0;
    coeff_addr = '0;
    if (active) begin
      if (k == CNT_W'(NTAPS)) begin
        rd_addr_a  = base - ADDR_W'(C);
        center_tap = 1'b1;
        coeff_addr = ADDR_W'(NTAPS);
      end else begin
        rd_addr_a  = base - k2;
        rd_addr_b  = base - ADDR_W'(L - 1) + k2;
        coeff_addr = ADDR_W'(k);
      end
    end
  end

endmodule

// File: rtl/hb_mac_sched.sv
// hb_mac_sched: sequencer sharing one halfband MAC between I and Q of a
// decimate-by-2 halfband filter.
// Ports:
//   clock, reset (async, active-low)
//   strobe_in          - new I/Q pair written at wr_addr this cycle
//   cfg_write/cfg_shift- load a pending MAC shift; also clears overrun
//   wr_addr            - ring write pointer
//   rd_addr_a/b, center_tap, coeff_addr, chan_sel - tap read addressing
//   mac_enable (operand-aligned), mac_clear, mac_shift - MAC control
//   capture_i/q, strobe_out - result-valid strobes
//   busy, overrun      - status
module hb_mac_sched
  import hb_mac_sched_pkg::*;
#(
  parameter int unsigned NTAPS     = 4,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned SHIFT_RST = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              strobe_in,
  input  logic              cfg_write,
  input  logic [7:0]        cfg_shift,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic              center_tap,
  output logic [ADDR_W-1:0] coeff_addr,
  output logic              chan_sel,
  output logic              mac_enable,
  output logic              mac_clear,
  output logic [7:0]        mac_shift,
  output logic              capture_i,
  output logic              capture_q,
  output logic              strobe_out,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned L     = filt_len(NTAPS);
  localparam int unsigned CNT_W = $clog2(NTAPS + RD_LAT + 2);

  if ((2 ** ADDR_W) < (L + 2)) begin : g_addr_check
    $error("hb_mac_sched: ADDR_W too small for the filter length");
  end

  state_t             state, next_state;
  logic [ADDR_W-1:0]  wr_ptr, base;
  logic               phase, chan, trig, run;
  logic [CNT_W-1:0]   cnt;
  logic [7:0]         pending_shift;
  logic [RD_LAT-1:0]  en_pipe;

  assign trig       = strobe_in & phase;
  assign busy       = (state != S_IDLE);
  assign wr_addr    = wr_ptr;
  assign chan_sel   = chan;
  assign mac_enable = en_pipe[RD_LAT-1];

  hb_tap_addr #(
    .NTAPS (NTAPS),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_tap_addr (
    .active    (run),
    .base      (base),
    .k         (cnt),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .center_tap(center_tap),
    .coeff_addr(coeff_addr)
  );

  always_comb begin
    next_state = state;
    mac_clear  = 1'b0;
    capture_i  = 1'b0;
    capture_q  = 1'b0;
    strobe_out = 1'b0;
    run        = 1'b0;
    case (state)
      S_IDLE:  if (trig) next_state = S_CLEAR;
      S_CLEAR: begin
        mac_clear  = 1'b1;
        next_state = S_RUN;
      end
      S_RUN: begin
        run = 1'b1;
        if (cnt == CNT_W'(NTAPS)) next_state = S_DRAIN;
      end
      // RD_LAT+1 cycles: operand latency plus the MAC product register.
      S_DRAIN: if (cnt == CNT_W'(RD_LAT)) next_state = S_CAPT;
      S_CAPT: begin
        capture_i  = ~chan;
        capture_q  = chan;
        next_state = chan ? S_STRB : S_CLEAR;
      end
      S_STRB: begin
        strobe_out = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      chan          <= 1'b0;
      base          <= '0;
      wr_ptr        <= '0;
      phase         <= 1'b0;
      overrun       <= 1'b0;
      pending_shift <= 8'(SHIFT_RST);
      mac_shift     <= 8'(SHIFT_RST);
      en_pipe       <= '0;
    end else begin
      state <= next_state;

      if (next_state != state)
        cnt <= '0;
      else if (state == S_RUN || state == S_DRAIN)
        cnt <= cnt + 1'b1;

      if (state == S_CAPT) chan <= ~chan;

      if (state == S_IDLE && trig) base <= wr_ptr;

      if (strobe_in) begin
        wr_ptr <= wr_ptr + 1'b1;
        phase  <= ~phase;
      end

      if (trig && busy)
        overrun <= 1'b1;
      else if (cfg_write)
        overrun <= 1'b0;

      if (cfg_write) pending_shift <= cfg_shift;

      // Shift updates only on edges that land in IDLE, so it is stable
      // across an entire computation; a same-cycle write bypasses pending.
      if (next_state == S_IDLE)
        mac_shift <= cfg_write ? cfg_shift : pending_shift;

      en_pipe[0] <= run;
      for (int unsigned i = 1; i < RD_LAT; i++)
        en_pipe[i] <= en_pipe[i-1];
    end
  end

endmodule
